// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// op encodings (RV32M funct3), FSM states and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic src1_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic src2_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared 2*XLEN accumulator with radix-2 shift-add multiply and restoring
// divide steps, operand magnitude conversion and result sign correction.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            special,
    output logic            special_dbz,
    output logic [XLEN-1:0] special_result,
    output logic [XLEN-1:0] final_result
);

    localparam logic [XLEN-1:0]   ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2    = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ALL_ONE = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   mag2_r;
    logic [2:0]        op_r;
    logic              neg_r;
    logic              sign1_r;

    logic              sign1_s, sign2_s, dbz_s, ovf_s, ge_s;
    logic [XLEN-1:0]   mag1_s, mag2_s, diff_s, quot_s, rem_s;
    logic [XLEN:0]     mul_sum_s, part_s;
    logic [2*XLEN-1:0] mul_next_s, div_next_s, acc_next_s, prod_s;

    assign sign1_s = src1_signed(op) & src1[XLEN-1];
    assign sign2_s = src2_signed(op) & src2[XLEN-1];
    assign mag1_s  = sign1_s ? (~src1 + ONE) : src1;
    assign mag2_s  = sign2_s ? (~src2 + ONE) : src2;

    assign dbz_s       = is_div(op) && (src2 == {XLEN{1'b0}});
    assign ovf_s       = ((op == OP_DIV) || (op == OP_REM)) && (src1 == MIN_NEG) && (src2 == ALL_ONE);
    assign special     = dbz_s | ovf_s;
    assign special_dbz = dbz_s;

    // Bypass values; op[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        special_result = src1;
        if (dbz_s) begin
            special_result = op[1] ? src1 : ALL_ONE;
        end else if (ovf_s) begin
            special_result = op[1] ? {XLEN{1'b0}} : src1;
        end else begin
            special_result = src1;
        end
    end

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mag2_r} : {(XLEN+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};

    // Divide: shift the next dividend bit into the remainder, subtract when it fits.
    assign part_s     = acc_r[2*XLEN-1:XLEN-1];
    assign ge_s       = (part_s >= {1'b0, mag2_r});
    assign diff_s     = part_s[XLEN-1:0] - mag2_r;
    assign div_next_s = ge_s ? {diff_s, acc_r[XLEN-2:0], 1'b1}
                             : {part_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};

    assign acc_next_s = is_div(op_r) ? div_next_s : mul_next_s;
    assign prod_s     = neg_r ? (~acc_next_s + ONE2) : acc_next_s;
    assign quot_s     = neg_r ? (~acc_next_s[XLEN-1:0] + ONE) : acc_next_s[XLEN-1:0];
    assign rem_s      = sign1_r ? (~acc_next_s[2*XLEN-1:XLEN] + ONE) : acc_next_s[2*XLEN-1:XLEN];

    // Sign-corrected result of the final iteration, selected by the latched op
    always_comb begin
        final_result = rem_s;
        case (op_r)
            OP_MUL:                       final_result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_result = quot_s;
            default:                      final_result = rem_s;
        endcase
    end

    // Operand latch at accept and one accumulator iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {(2*XLEN){1'b0}};
            mag2_r  <= {XLEN{1'b0}};
            op_r    <= OP_MUL;
            neg_r   <= 1'b0;
            sign1_r <= 1'b0;
        end else if (load) begin
            acc_r   <= {{XLEN{1'b0}}, mag1_s};
            mag2_r  <= mag2_s;
            op_r    <= op;
            neg_r   <= sign1_s ^ sign2_s;
            sign1_r <= sign1_s;
        end else if (step) begin
            acc_r   <= acc_next_s;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: IDLE/CALC/DONE control around the iterative
// datapath, with valid/ready handshakes on both the operand and result sides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);

    state_t          state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [XLEN-1:0] result_r;
    logic            dbz_r, out_valid_r, in_ready_r;
    logic            load_s, step_s, wr_special_s, wr_final_s;
    logic            special_s, special_dbz_s;
    logic [XLEN-1:0] special_result_s, final_result_s;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load_s),
        .step           (step_s),
        .op             (op),
        .src1           (src1),
        .src2           (src2),
        .special        (special_s),
        .special_dbz    (special_dbz_s),
        .special_result (special_result_s),
        .final_result   (final_result_s)
    );

    // Next-state, counter and datapath control; flush overrides everything
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        wr_special_s = 1'b0;
        wr_final_s   = 1'b0;
        if (flush) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        load_s    = 1'b1;
                        cnt_nxt_s = CNT_FULL;
                        if (special_s) begin
                            state_nxt_s  = ST_DONE;
                            wr_special_s = 1'b1;
                        end else begin
                            state_nxt_s  = ST_CALC;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    step_s    = 1'b1;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_DONE;
                        wr_final_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, counter and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {XLEN{1'b0}};
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= (state_nxt_s == ST_DONE);
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            if (wr_special_s) begin
                result_r <= special_result_s;
                dbz_r    <= special_dbz_s;
            end else if (wr_final_s) begin
                result_r <= final_result_s;
                dbz_r    <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32) with hand-computed
// results, latency, backpressure, flush and mid-operation reset checks.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [2:0]  op;
    logic [31:0] src1, src2, result;
    int          errors = 0;
    int          checks = 0;
    int          seen;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, wait for out_valid (bounded).
    // exp_lat counts edges after the accept edge (0 for bypass cases).
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_dbz, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; src1 = ~a; src2 = 32'd0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic accept_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32);
        accept_result("mul");
        run_op("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32);
        accept_result("mulhu");
        run_op("mulh", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 32);
        accept_result("mulh");
        run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32);
        accept_result("mulhsu");
        run_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 32);
        accept_result("div");
        run_op("rem", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 32);
        accept_result("rem");
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0);
        accept_result("div_ovf");
        run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 0);
        accept_result("rem_ovf");
        run_op("div0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 0);
        accept_result("div0");
        run_op("remu", OP_REMU, 32'hFFFFFFF9, 32'd2, 32'd1, 1'b0, 32);
        accept_result("remu");

        // Backpressure: result and flags held while out_ready stays low
        run_op("divu", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 1'b0, 32);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'h7FFFFFFC);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        accept_result("bp");

        // flush wins over a simultaneous in_valid
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = OP_MUL; src1 = 32'd2; src2 = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_prio_in_ready", {31'd0, in_ready}, 32'd1);

        // flush during CALC: no result ever delivered
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 32'd0);

        run_op("rem0", OP_REM, 32'd5, 32'd0, 32'd5, 1'b1, 0);
        accept_result("rem0");

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        in_valid = 1'b1; op = OP_MUL; src1 = 32'd5; src2 = 32'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_after_rst", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 32);
        accept_result("mul_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the RV32M extension, with a parametrised datapath width. It runs alongside the combinational ALU in the execute stage and takes over all MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU work. The core is a radix-2 shift-add multiplier and a restoring divider, sharing one 2*XLEN accumulator. Operands enter through a valid/ready handshake; results leave through a second valid/ready handshake, so the core can stall the pipeline.

Parameters:
XLEN, 32, operand/result width; any even value >= 8
CNT_W, $clog2(XLEN+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  aborts any in-flight operation (pipeline redirect)
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept; high only in IDLE
op  input  3  operation; encoding equals RV32M funct3 (0 MUL … 7 REMU)
src1  input  XLEN  rs1 value
src2  input  XLEN  rs2 value
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
result  output  XLEN  registered result
div_by_zero  output  1  registered flag; set with result for DIV/DIVU/REM/REMU with src2==0

Behaviour:
- Clock/reset decided: one clock, clk; rst_n asynchronous, active-low. In reset: state=IDLE, out_valid=0, result=0, div_by_zero=0, counter=0, accumulator=0. in_ready=1 once reset deasserts.
- FSM states: IDLE, CALC, DONE.
- IDLE: when in_valid&in_ready&!flush, latch op and operands; go to CALC with counter=XLEN.
- Special cases bypass CALC and go to DONE on the next edge (latency 1):
  - Divide by zero: quotient = all ones, remainder = src1, div_by_zero=1.
  - Signed overflow (DIV/REM, src1=MSB-only, src2=all ones): quotient = src1, remainder = 0.
- CALC: one iteration per cycle; counter decrements. At the edge where counter goes 1->0, the sign-corrected result is written to `result` and the FSM enters DONE. Normal latency is XLEN edges from the accept edge to out_valid=1.
- Signed handling: operands are converted to magnitudes before iteration.
  - src1 is signed for MULH, MULHSU, DIV and REM.
  - src2 is signed for MULH, DIV and REM.
  - Product is negated when sign1^sign2.
  - Quotient is negated when sign1^sign2; remainder takes sign1.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- DONE: out_valid=1; result and div_by_zero are stable. out_valid&out_ready -> IDLE next edge, out_valid=0. No new op is accepted in the same cycle (in_ready is low in DONE).
- flush (any state) -> IDLE on the next edge, out_valid=0, no result delivered. flush has priority over an in_valid in the same cycle and over out_ready.
- Asynchronous reset mid-CALC/DONE immediately clears state and outputs; no partial result is ever signalled.
- Inputs are sampled only at the accept edge; changing src1/src2/op afterwards has no effect.
- div_by_zero=0 for all non-division results and for non-zero divisors.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MUL=0, OP_MULH=1, OP_MULHSU=2, OP_MULHU=3, OP_DIV=4, OP_DIVU=5, OP_REM=6, OP_REMU=7.
  - FSM state enum.
  - helper functions is_div(op), src1_signed(op), src2_signed(op).
- One sub-module, muldiv_datapath: accumulator, magnitude/negate logic, and the per-cycle shift-add/subtract step. It is driven by the FSM and counter in muldiv_unit.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB exactly 32 edges after accept; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIV 5/0 -> 0xFFFFFFFF with div_by_zero=1 after 1 edge; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with flag 0; REM -> 0.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and result held; in_ready stays 0; accept -> IDLE, in_ready=1 next cycle.
- flush at CALC cycle 5 -> IDLE next edge, out_valid never rises; rst_n pulse mid-CALC -> outputs zero immediately; the following MUL 3*4 -> 12.
